// File: rtl/topk_pkg.sv
// Shared compare helper and default width constants for the top-K tracker.
package topk_pkg;

  localparam int K_DEF  = 4;
  localparam int RANK_W = $clog2(K_DEF);
  localparam int CNT_W  = $clog2(K_DEF + 1);
  localparam int MAX_W  = 64;

  // Callers extend operands to MAX_W first (sign- or zero-extension matching signed_mode).
  function automatic logic topk_better(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input logic             signed_mode,
                                       input logic             min_mode);
    logic ge;
    logic le;
    if (signed_mode) begin
      ge = ($signed(a) >= $signed(b));
      le = ($signed(a) <= $signed(b));
    end else begin
      ge = (a >= b);
      le = (a <= b);
    end
    return min_mode ? le : ge;
  endfunction

endpackage

// File: rtl/topk_slot.sv
// One rank of the sorted list: holds its value/valid, loads the new sample or
// the left neighbour, and flags whether the incoming sample belongs at or above it.
module topk_slot
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 0,
  parameter int TRACK_MIN  = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  ins_here,
  input  logic                  shift_here,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] left_e,
  input  logic                  left_v,
  output logic [DATA_WIDTH-1:0] e,
  output logic                  v,
  output logic                  take
);

  logic [MAX_W-1:0] din_x;
  logic [MAX_W-1:0] e_x;

  if (SIGNED != 0) begin : g_sx
    assign din_x = MAX_W'($signed(din));
    assign e_x   = MAX_W'($signed(e));
  end else begin : g_zx
    assign din_x = MAX_W'(din);
    assign e_x   = MAX_W'(e);
  end

  assign take = !v || topk_better(din_x, e_x, (SIGNED != 0), (TRACK_MIN != 0));

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      e <= '0;
      v <= 1'b0;
    end else if (ins_here) begin
      e <= din;
      v <= 1'b1;
    end else if (shift_here) begin
      e <= left_e;
      v <= left_v;
    end
  end

endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: sorted register list, best first, one-cycle update latency.
// No backpressure: every valid sample is accepted; clear flushes and wins over din.
module topk_tracker
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int SIGNED     = 0,
  parameter int TRACK_MIN  = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   din_valid,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   clear,
  input  logic [$clog2(K)-1:0]   rank_sel,
  output logic [DATA_WIDTH-1:0]  rank_dout,
  output logic [DATA_WIDTH-1:0]  kth_dout,
  output logic [$clog2(K+1)-1:0] count,
  output logic                   full
);

  localparam int RW = $clog2(K);
  localparam int CW = $clog2(K + 1);

  logic [DATA_WIDTH-1:0] e_arr [K];
  logic [K-1:0]          v_arr;
  logic [K-1:0]          take;
  logic [K:0]            below;
  logic [K-1:0]          ins;
  logic [K-1:0]          shift;

  // below[i]: some higher-ranked slot already claims the sample, so slot i shifts.
  assign below[0] = 1'b0;

  for (genvar i = 0; i < K; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] left_e;
    logic                  left_v;

    if (i == 0) begin : g_head
      assign left_e = '0;
      assign left_v = 1'b0;
    end else begin : g_body
      assign left_e = e_arr[i-1];
      assign left_v = v_arr[i-1];
    end

    assign below[i+1] = below[i] | take[i];
    assign ins[i]     = din_valid & take[i] & ~below[i];
    assign shift[i]   = din_valid & below[i];

    topk_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIGNED     (SIGNED),
      .TRACK_MIN  (TRACK_MIN)
    ) u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (clear),
      .ins_here   (ins[i]),
      .shift_here (shift[i]),
      .din        (din),
      .left_e     (left_e),
      .left_v     (left_v),
      .e          (e_arr[i]),
      .v          (v_arr[i]),
      .take       (take[i])
    );
  end

  // Unmatched rank_sel codes (non-power-of-2 K) fall through to zero.
  always_comb begin
    rank_dout = '0;
    for (int i = 0; i < K; i++) begin
      if (rank_sel == RW'(i) && v_arr[i]) begin
        rank_dout = e_arr[i];
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < K; i++) begin
      count = count + CW'(v_arr[i]);
    end
  end

  assign full     = v_arr[K-1];
  assign kth_dout = v_arr[K-1] ? e_arr[K-1] : '0;

endmodule

// File: tb/tb_topk_tracker.sv
// Scoreboard bench: unsigned-max and signed-min instances share one stimulus stream.
module tb_topk_tracker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       din_valid;
  logic [7:0] din;
  logic       clear;
  logic [1:0] rank_sel;
  logic [7:0] rd0, kth0, rd1, kth1;
  logic [2:0] cnt0, cnt1;
  logic       full0, full1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0][7:0] r;
    logic [2:0]      cnt;
    logic            full;
    logic [7:0]      kth;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] m [2][4];
  int         n [2];

  always #5 clk = ~clk;

  topk_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED(0), .TRACK_MIN(0)) u0 (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
    .rank_sel(rank_sel), .rank_dout(rd0), .kth_dout(kth0), .count(cnt0), .full(full0)
  );

  topk_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED(1), .TRACK_MIN(1)) u1 (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
    .rank_sel(rank_sel), .rank_dout(rd1), .kth_dout(kth1), .count(cnt1), .full(full1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_better(input logic [7:0] a, input logic [7:0] b, input int k);
    if (k == 1) return $signed(a) <= $signed(b);
    return a >= b;
  endfunction

  // Reference: insert into a sorted array, ties placed ahead of equal entries.
  task automatic ref_insert(input int k, input logic [7:0] d);
    int p = 4;
    for (int i = 3; i >= 0; i--) begin
      if (i >= n[k] || ref_better(d, m[k][i], k)) p = i;
    end
    if (p < 4) begin
      for (int i = 3; i > p; i--) m[k][i] = m[k][i-1];
      m[k][p] = d;
      if (n[k] < 4) n[k]++;
    end
  endtask

  function automatic exp_t ref_out(input int k);
    exp_t x;
    for (int i = 0; i < 4; i++) x.r[i] = (i < n[k]) ? m[k][i] : 8'h00;
    x.cnt  = 3'(n[k]);
    x.full = (n[k] == 4);
    x.kth  = (n[k] == 4) ? m[k][3] : 8'h00;
    return x;
  endfunction

  task automatic read_ranks(input int k, output logic [3:0][7:0] r);
    for (int i = 0; i < 4; i++) begin
      rank_sel = 2'(i);
      #1;
      r[i] = (k == 0) ? rd0 : rd1;
    end
  endtask

  task automatic compare(input int k, input exp_t x);
    logic [3:0][7:0] r;
    read_ranks(k, r);
    for (int i = 0; i < 4; i++) check($sformatf("u%0d_rank%0d", k, i), 32'(r[i]), 32'(x.r[i]));
    check($sformatf("u%0d_count", k), 32'(k == 0 ? cnt0 : cnt1), 32'(x.cnt));
    check($sformatf("u%0d_full", k), 32'(k == 0 ? full0 : full1), 32'(x.full));
    check($sformatf("u%0d_kth", k), 32'(k == 0 ? kth0 : kth1), 32'(x.kth));
  endtask

  task automatic step(input bit rst, input bit vld, input logic [7:0] d, input bit clr);
    resetn    = !rst;
    din_valid = vld;
    din       = d;
    clear     = clr;
    for (int k = 0; k < 2; k++) begin
      if (rst || clr) n[k] = 0;
      else if (vld) ref_insert(k, d);
    end
    q0.push_back(ref_out(0));
    q1.push_back(ref_out(1));
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    din_valid = 1'b0;
    clear     = 1'b0;
    compare(0, q0.pop_front());
    compare(1, q1.pop_front());
  endtask

  // Directed check on the unsigned-max instance against literal expectations.
  task automatic direct0(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input int cnt, input bit f, input logic [7:0] kth);
    logic [3:0][7:0] r;
    read_ranks(0, r);
    check({tag, "_r0"}, 32'(r[0]), 32'(a));
    check({tag, "_r1"}, 32'(r[1]), 32'(b));
    check({tag, "_r2"}, 32'(r[2]), 32'(c));
    check({tag, "_r3"}, 32'(r[3]), 32'(d));
    check({tag, "_cnt"}, 32'(cnt0), 32'(cnt));
    check({tag, "_full"}, 32'(full0), 32'(f));
    check({tag, "_kth"}, 32'(kth0), 32'(kth));
  endtask

  initial begin
    resetn = 1'b0; din_valid = 1'b0; din = 8'h00; clear = 1'b0; rank_sel = 2'd0;
    n[0] = 0; n[1] = 0;

    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h11, 0);
    direct0("reset", 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 8'd3, 0); step(0, 1, 8'd9, 0); step(0, 1, 8'd1, 0);
    direct0("three", 9, 3, 1, 0, 3, 0, 0);
    step(0, 1, 8'd7, 0); step(0, 1, 8'd2, 0); step(0, 1, 8'd8, 0);
    direct0("fill", 9, 8, 7, 3, 4, 1, 3);
    step(0, 1, 8'd1, 0);
    direct0("worse", 9, 8, 7, 3, 4, 1, 3);

    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 8'd5, 0);
    direct0("ties", 5, 5, 5, 5, 4, 1, 5);
    step(0, 1, 8'd5, 0);
    direct0("ties2", 5, 5, 5, 5, 4, 1, 5);

    step(0, 0, 8'h00, 1);
    step(0, 1, 8'hFD, 0); step(0, 1, 8'h04, 0); step(0, 1, 8'h80, 0); step(0, 1, 8'h00, 0);
    begin
      logic [3:0][7:0] r;
      read_ranks(1, r);
      check("smin_r0", 32'(r[0]), 32'h80);
      check("smin_r1", 32'(r[1]), 32'hFD);
      check("smin_r2", 32'(r[2]), 32'h00);
      check("smin_r3", 32'(r[3]), 32'h04);
    end

    step(0, 1, 8'd50, 1);
    direct0("clr_din", 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'd10, 0); step(0, 1, 8'd20, 0); step(0, 0, 8'd99, 0);
    direct0("gap", 20, 10, 0, 0, 2, 0, 0);
    step(1, 1, 8'd77, 0);
    direct0("midrst", 0, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 10000; t++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
